// File: rtl/xaddr_decoder_n.sv
// xaddr_decoder_n: registered N-slave address decoder with wait states and trap.
// Define XADDR_TRAP_STATS_EN to add the trap_cnt / trap_addr statistics ports.
module xaddr_decoder_n #(
    parameter int                      ADDR_W   = 16,
    parameter int                      DATA_W   = 32,
    parameter int                      N_SLV    = 4,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {16'h2000, 16'h1100, 16'h1000, 16'h0000},
    parameter logic [N_SLV*8-1:0]      SLV_AW   = {8'd8, 8'd2, 8'd4, 8'd12},
    parameter int                      TMO_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    sel,
    output logic                    ready,
    output logic [DATA_W-1:0]       data_to_rd,
    output logic                    trap,
    output logic [N_SLV-1:0]        slv_sel,
    input  logic [N_SLV-1:0]        slv_ready,
    input  logic [N_SLV*DATA_W-1:0] slv_data_to_rd
`ifdef XADDR_TRAP_STATS_EN
    ,
    output logic [15:0]             trap_cnt,
    output logic [ADDR_W-1:0]       trap_addr
`endif
);

    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [TMO_W-1:0]  r_cnt;
    logic              r_ready;
    logic              r_trap;
    logic [N_SLV-1:0]  r_slv_sel;
    logic [DATA_W-1:0] r_data;

    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic              w_sready;
    logic [DATA_W-1:0] w_sdata;
    logic              w_miss;
    logic              w_tmo;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (((addr ^ SLV_BASE[i*ADDR_W +: ADDR_W]) >> SLV_AW[i*8 +: 8]) == '0) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
    end

    assign w_sready = slv_ready[r_idx];
    assign w_sdata  = slv_data_to_rd[r_idx*DATA_W +: DATA_W];
    assign w_miss   = (r_state == S_IDLE) && sel && !w_hit;
    assign w_tmo    = (r_state == S_BUSY) && !w_sready && (r_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_trap    <= 1'b0;
            r_slv_sel <= '0;
            r_data    <= '0;
        end else begin
            r_ready <= 1'b0;
            r_trap  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sel && w_hit) begin
                        r_idx     <= w_idx;
                        r_slv_sel <= N_SLV'(1) << w_idx;
                        r_cnt     <= '0;
                        r_state   <= S_BUSY;
                    end else if (w_miss) begin
                        r_ready <= 1'b1;
                        r_trap  <= 1'b1;
                        r_data  <= '0;
                        r_state <= S_RESP;
                    end
                end
                S_BUSY: begin
                    if (w_sready) begin
                        r_data    <= w_sdata;
                        r_slv_sel <= '0;
                        r_ready   <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_tmo) begin
                            r_data    <= '0;
                            r_slv_sel <= '0;
                            r_ready   <= 1'b1;
                            r_trap    <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready      = r_ready;
    assign trap       = r_trap;
    assign slv_sel    = r_slv_sel;
    assign data_to_rd = r_data;

`ifdef XADDR_TRAP_STATS_EN
    logic [15:0]       r_trap_cnt;
    logic [ADDR_W-1:0] r_trap_addr;
    logic [ADDR_W-1:0] r_acc_addr;

    // A timed-out access reports the address captured when it was accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap_cnt  <= '0;
            r_trap_addr <= '0;
            r_acc_addr  <= '0;
        end else begin
            if (r_state == S_IDLE && sel)
                r_acc_addr <= addr;
            if (w_miss || w_tmo) begin
                if (r_trap_cnt != 16'hFFFF)
                    r_trap_cnt <= r_trap_cnt + 16'd1;
                r_trap_addr <= w_miss ? addr : r_acc_addr;
            end
        end
    end

    assign trap_cnt  = r_trap_cnt;
    assign trap_addr = r_trap_addr;
`endif

endmodule

// File: tb/tb_xaddr_decoder_n.sv
// tb_xaddr_decoder_n: directed bench for xaddr_decoder_n with a transaction-level model.
// Also covers the XADDR_TRAP_STATS_EN ports when that macro is defined.
module tb_xaddr_decoder_n;

    localparam int TMO = 15;
    localparam int NC  = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0;
    logic        sel = 1'b0;
    logic        ready;
    logic [31:0] data_to_rd;
    logic        trap;
    logic [3:0]  slv_sel;
    logic [3:0]  slv_ready;
    logic [127:0] slv_data_to_rd;
`ifdef XADDR_TRAP_STATS_EN
    logic [15:0] trap_cnt;
    logic [15:0] trap_addr;
`endif

    bit [31:0] sd [4] = '{32'hDEAD_BEEF, 32'h0000_1234, 32'hC0DE_0002, 32'hA5A5_0003};
    int m_base [4] = '{'h0000, 'h1000, 'h1100, 'h2000};
    int m_aw   [4] = '{12, 4, 2, 8};

    int cyc = 0;
    bit [3:0] rdy_mask = 4'b0;
    bit [3:0] r_other  = 4'b0;
    bit       rdy_on   = 1'b0;
    int       rdy_from = 0;

    assign slv_data_to_rd = {sd[3], sd[2], sd[1], sd[0]};
    assign slv_ready = r_other | ((rdy_on && cyc >= rdy_from) ? rdy_mask : 4'b0);

    xaddr_decoder_n dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .sel            (sel),
        .ready          (ready),
        .data_to_rd     (data_to_rd),
        .trap           (trap),
        .slv_sel        (slv_sel),
        .slv_ready      (slv_ready),
        .slv_data_to_rd (slv_data_to_rd)
`ifdef XADDR_TRAP_STATS_EN
        ,
        .trap_cnt       (trap_cnt),
        .trap_addr      (trap_addr)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle outputs, filled from transaction descriptions
    bit        e_ready [NC];
    bit        e_trap  [NC];
    bit [3:0]  e_sel   [NC];
    bit [31:0] e_data  [NC];
    bit [15:0] e_taddr [NC];
    bit        e_rst   [NC];

    // Hand-computed literal pins
    bit        p_sel_en [NC];
    bit [3:0]  p_sel_v  [NC];
    bit        p_rt_en  [NC];
    bit        p_rdy_v  [NC];
    bit        p_trap_v [NC];
    bit        p_d_en   [NC];
    bit [31:0] p_d_v    [NC];
    bit        p_tc_en  [NC];
    bit [15:0] p_tc_v   [NC];
    bit [15:0] p_ta_v   [NC];

    int win_lo = -10;
    int win_hi = -10;
    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    function automatic int m_decode(input int a);
        for (int i = 0; i < 4; i++) begin
            int sz = 1 << m_aw[i];
            if (a / sz == m_base[i] / sz) return i;
        end
        return -1;
    endfunction

    task automatic plan(input int t0, input int a, input int w, output int resp);
        int idx = m_decode(a);
        int busy;
        bit [15:0] a16 = a[15:0];
        if (idx < 0) begin
            resp = t0 + 1;
            e_ready[resp] = 1'b1;
            e_trap[resp]  = 1'b1;
            e_data[resp]  = 32'h0;
            e_taddr[resp] = a16;
        end else begin
            busy = (w >= 0 && w < TMO) ? w + 1 : TMO;
            for (int k = 1; k <= busy; k++) e_sel[t0+k] = 4'(1 << idx);
            resp = t0 + busy + 1;
            e_ready[resp] = 1'b1;
            if (w >= 0 && w < TMO) begin
                e_data[resp] = sd[idx];
            end else begin
                e_trap[resp]  = 1'b1;
                e_data[resp]  = 32'h0;
                e_taddr[resp] = a16;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int a, input int w, input bit [3:0] other);
        int t0 = cyc;
        int idx = m_decode(a);
        int resp;
        plan(t0, a, w, resp);
        addr     = a[15:0];
        sel      = 1'b1;
        rdy_mask = (idx >= 0) ? 4'(1 << idx) : 4'b0;
        rdy_on   = (w >= 0);
        rdy_from = t0 + 1 + w;
        r_other  = other & ~rdy_mask;
        step();
        sel  = 1'b0;
        addr = 16'hFFFF;
        while (cyc <= resp) step();
        rdy_on  = 1'b0;
        r_other = 4'b0;
    endtask

    task automatic pin_sel(input int c, input bit [3:0] v);
        p_sel_en[c] = 1'b1;
        p_sel_v[c]  = v;
    endtask

    task automatic pin_rt(input int c, input bit r, input bit t);
        p_rt_en[c]  = 1'b1;
        p_rdy_v[c]  = r;
        p_trap_v[c] = t;
    endtask

    task automatic pin_d(input int c, input bit [31:0] v);
        p_d_en[c] = 1'b1;
        p_d_v[c]  = v;
    endtask

    task automatic pin_tc(input int c, input bit [15:0] n, input bit [15:0] a);
        p_tc_en[c] = 1'b1;
        p_tc_v[c]  = n;
        p_ta_v[c]  = a;
    endtask

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, exp);
        end
    endtask

    // Single compare process
    bit [31:0] m_data  = 32'h0;
    bit [15:0] m_tcnt  = 16'h0;
    bit [15:0] m_taddr = 16'h0;
    bit        prev_rdy = 1'b0;
    int        pulses = 0;

    always @(negedge clk) begin
        int c;
        c = cyc;
        if (chk_en && c < NC) begin
            if (e_rst[c]) begin
                m_data  = 32'h0;
                m_tcnt  = 16'h0;
                m_taddr = 16'h0;
            end
            if (e_ready[c]) m_data = e_data[c];
            if (e_trap[c]) begin
                if (m_tcnt != 16'hFFFF) m_tcnt++;
                m_taddr = e_taddr[c];
            end
            chk("ready", c, 64'(ready), 64'(e_ready[c]));
            chk("trap", c, 64'(trap), 64'(e_trap[c]));
            chk("slv_sel", c, 64'(slv_sel), 64'(e_sel[c]));
            chk("data_to_rd", c, 64'(data_to_rd), 64'(m_data));
            chk("no_b2b_ready", c, 64'(ready & prev_rdy), 64'(0));
`ifdef XADDR_TRAP_STATS_EN
            chk("trap_cnt", c, 64'(trap_cnt), 64'(m_tcnt));
            chk("trap_addr", c, 64'(trap_addr), 64'(m_taddr));
            if (p_tc_en[c]) begin
                chk("pin_trap_cnt", c, 64'(trap_cnt), 64'(p_tc_v[c]));
                chk("pin_trap_addr", c, 64'(trap_addr), 64'(p_ta_v[c]));
            end
`endif
            if (p_sel_en[c]) chk("pin_slv_sel", c, 64'(slv_sel), 64'(p_sel_v[c]));
            if (p_rt_en[c]) begin
                chk("pin_ready", c, 64'(ready), 64'(p_rdy_v[c]));
                chk("pin_trap", c, 64'(trap), 64'(p_trap_v[c]));
            end
            if (p_d_en[c]) chk("pin_data", c, 64'(data_to_rd), 64'(p_d_v[c]));
            if (c >= win_lo && c <= win_hi && ready === 1'b1) pulses++;
            if (c == win_hi + 1) chk("held_sel_pulses", c, 64'(pulses), 64'(3));
            prev_rdy = (ready === 1'b1);
        end
    end

    int va [6] = '{'h0FFF, 'h1010, 'h1103, 'h20FF, 'h1104, 'h2100};
    int vw [6] = '{1, -1, 2, 0, -1, -1};

    initial begin
        int t;
        int r;
        step();
        step();
        pin_rt(2, 1'b0, 1'b0);
        pin_sel(2, 4'b0000);
        pin_d(2, 32'h0);
        chk_en = 1'b1;
        rst    = 1'b0;
        step();

        t = cyc;
        pin_sel(t + 1, 4'b0001);
        pin_rt(t + 2, 1'b1, 1'b0);
        pin_d(t + 2, 32'hDEADBEEF);
        txn('h0ABC, 0, 4'b0000);

        t = cyc;
        for (int k = 1; k <= 4; k++) pin_sel(t + k, 4'b0010);
        pin_sel(t + 5, 4'b0000);
        pin_rt(t + 5, 1'b1, 1'b0);
        pin_d(t + 5, 32'h0000_1234);
        txn('h100F, 3, 4'b1101);

        t = cyc;
        pin_sel(t + 1, 4'b0000);
        pin_rt(t + 1, 1'b1, 1'b1);
        pin_d(t + 1, 32'h0);
        pin_tc(t + 1, 16'd1, 16'h3000);
        txn('h3000, -1, 4'b0000);

        t = cyc;
        pin_sel(t + 15, 4'b1000);
        pin_sel(t + 16, 4'b0000);
        pin_rt(t + 15, 1'b0, 1'b0);
        pin_rt(t + 16, 1'b1, 1'b1);
        pin_d(t + 16, 32'h0);
        txn('h2010, -1, 4'b0111);

        t = cyc;
        pin_rt(t + 16, 1'b1, 1'b0);
        pin_d(t + 16, 32'hA5A5_0003);
        txn('h20FF, 14, 4'b0000);

        t = cyc;
        plan(t, 'h1102, 0, r);
        plan(t + 3, 'h1102, 0, r);
        plan(t + 6, 'h1102, 0, r);
        win_lo   = t;
        win_hi   = t + 8;
        addr     = 16'h1102;
        sel      = 1'b1;
        rdy_mask = 4'b0100;
        rdy_from = t + 1;
        rdy_on   = 1'b1;
        repeat (7) step();
        sel = 1'b0;
        repeat (2) step();
        rdy_on = 1'b0;

        for (int i = 0; i < 6; i++) txn(va[i], vw[i], 4'b0000);

        t = cyc;
        e_sel[t + 1] = 4'(1 << m_decode('h0004));
        e_sel[t + 2] = 4'(1 << m_decode('h0004));
        e_rst[t + 3] = 1'b1;
        pin_sel(t + 3, 4'b0000);
        pin_rt(t + 3, 1'b0, 1'b0);
        pin_d(t + 3, 32'h0);
        addr = 16'h0004;
        sel  = 1'b1;
        step();
        sel = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();

        t = cyc;
        pin_rt(t + 1, 1'b1, 1'b1);
        pin_tc(t + 1, 16'd1, 16'h1104);
        txn('h1104, -1, 4'b0000);
        txn('h0ABC, 2, 4'b0000);

        repeat (2) step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

endmodule
